// File: rtl/demux5_buffered_if.sv
// Handshake bundle for demux5_buffered: one producer-side input port and
// N_OUT independent one-entry output slots with error/discard status.
interface demux5_buffered_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_OUT  = 5,
  parameter int unsigned CNT_W  = 8
);
  logic [2:0]              state;
  logic                    in_valid;
  logic [DATA_W-1:0]       in_data;
  logic                    in_ready;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT-1:0]        out_ready;
  logic                    err;
  logic                    err_clr;
  logic [CNT_W-1:0]        discard_cnt;

  modport master (
    output state, in_valid, in_data, out_ready, err_clr,
    input  in_ready, out_data, out_valid, err, discard_cnt
  );

  modport slave (
    input  state, in_valid, in_data, out_ready, err_clr,
    output in_ready, out_data, out_valid, err, discard_cnt
  );
endinterface

// File: rtl/demux5_buffered.sv
// Registered 1-to-N_OUT write distributor: steers each accepted word into a
// one-entry buffer per destination; invalid selects are discarded and counted.
module demux5_buffered #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_OUT  = 5,
  parameter int unsigned CNT_W  = 8
) (
  input logic              clk,
  input logic              reset,
  demux5_buffered_if.slave bus
);

  logic [N_OUT-1:0]             full_q, full_d;
  logic [N_OUT-1:0][DATA_W-1:0] data_q, data_d;
  logic                         err_q, err_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         sel_ok;
  logic                         in_ready;
  logic                         accept;

  // Invalid selects never stall the producer; valid ones pass through a draining slot.
  always_comb begin
    sel_ok   = 1'b0;
    in_ready = 1'b1;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (bus.state == 3'(i)) begin
        sel_ok   = 1'b1;
        in_ready = !full_q[i] || bus.out_ready[i];
      end
    end
  end

  assign accept = bus.in_valid && in_ready;

  // A write to a slot wins over its drain in the same cycle.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (accept && bus.state == 3'(i)) begin
        data_d[i] = bus.in_data;
        full_d[i] = 1'b1;
      end else if (full_q[i] && bus.out_ready[i]) begin
        full_d[i] = 1'b0;
      end
    end
  end

  // Clear first, then a concurrent discard sets err and counts from zero.
  always_comb begin
    err_d = err_q && !bus.err_clr;
    cnt_d = bus.err_clr ? '0 : cnt_q;
    if (accept && !sel_ok) begin
      err_d = 1'b1;
      if (cnt_d != '1) begin
        cnt_d = cnt_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = full_q;
  assign bus.out_data    = data_q;
  assign bus.err         = err_q;
  assign bus.discard_cnt = cnt_q;

endmodule

// File: tb/tb_demux5_buffered.sv
// Directed bench for demux5_buffered: scoreboard of expected slot deliveries
// plus direct checks of handshake, error and reset behaviour.
module tb_demux5_buffered;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned N_OUT  = 5;
  localparam int unsigned CNT_W  = 8;

  logic clk;
  logic reset;

  demux5_buffered_if #(.DATA_W(DATA_W), .N_OUT(N_OUT), .CNT_W(CNT_W)) bus ();

  demux5_buffered #(.DATA_W(DATA_W), .N_OUT(N_OUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int          slot;
    logic [31:0] data;
  } sb_t;

  sb_t sb[$];
  int  total = 0;
  int  bad   = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int slot, input logic [31:0] data);
    sb_t e;
    e.slot = slot;
    e.data = data;
    sb.push_back(e);
  endtask

  // Pop the oldest expected delivery and compare it with the slot contents.
  task automatic sb_check(input string tag);
    sb_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=scoreboard_empty expected=pending_entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 160'(bus.out_valid[e.slot]), 160'(1'b1));
      chk({tag, "_data"}, 160'(bus.out_data[e.slot*DATA_W +: DATA_W]), 160'(e.data));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Upstream protocol monitor: select must not change while stalled.
  logic       prev_stall;
  logic [2:0] prev_state;
  always @(posedge clk) begin
    if (!reset && prev_stall && bus.in_valid && bus.state !== prev_state) begin
      bad++;
      $error("FAIL protocol observed_state=%0d expected_state=%0d", bus.state, prev_state);
    end
    prev_stall <= bus.in_valid && !bus.in_ready;
    prev_state <= bus.state;
  end

  initial begin
    clk           = 1'b0;
    reset         = 1'b1;
    prev_stall    = 1'b0;
    prev_state    = '0;
    bus.state     = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = '0;
    bus.err_clr   = 1'b0;
    #12 reset = 1'b0;
    step();

    // Reset / idle
    for (int s = 0; s < 5; s++) begin
      bus.state = 3'(s);
      #1;
      chk($sformatf("idle_ready_s%0d", s), 160'(bus.in_ready), 160'(1'b1));
    end
    chk("rst_out_valid", 160'(bus.out_valid), 160'(5'b00000));
    chk("rst_out_data", bus.out_data, 160'd0);
    chk("rst_err", 160'(bus.err), 160'(1'b0));
    chk("rst_cnt", 160'(bus.discard_cnt), 160'(8'd0));
    step();

    // Single write to slot 2, stall, then overwrite while draining
    bus.state = 3'd2; bus.in_data = 32'hDEADBEEF; bus.in_valid = 1'b1;
    #1;
    chk("w2_ready", 160'(bus.in_ready), 160'(1'b1));
    push(2, 32'hDEADBEEF);
    step();
    bus.in_data = 32'h12345678;
    #1;
    chk("w2_valid", 160'(bus.out_valid), 160'(5'b00100));
    chk("w2_stall_ready", 160'(bus.in_ready), 160'(1'b0));
    step();
    chk("w2_hold_valid", 160'(bus.out_valid), 160'(5'b00100));
    bus.out_ready = 5'b00100;
    #1;
    chk("w2_pass_ready", 160'(bus.in_ready), 160'(1'b1));
    sb_check("w2_first");
    push(2, 32'h12345678);
    step();
    bus.in_valid = 1'b0; bus.out_ready = '0;
    #1;
    chk("w2_still_valid", 160'(bus.out_valid), 160'(5'b00100));
    bus.out_ready = 5'b00100;
    #1;
    sb_check("w2_second");
    step();
    bus.out_ready = '0;
    #1;
    chk("w2_empty", 160'(bus.out_valid), 160'(5'b00000));

    // Stream into slot 0 with continuous drain
    bus.out_ready = 5'b00001;
    for (int k = 1; k <= 4; k++) begin
      bus.state = 3'd0; bus.in_data = 32'(k); bus.in_valid = 1'b1;
      #1;
      chk($sformatf("stream_ready_%0d", k), 160'(bus.in_ready), 160'(1'b1));
      if (k > 1) sb_check($sformatf("stream_out_%0d", k - 1));
      push(0, 32'(k));
      step();
    end
    bus.in_valid = 1'b0;
    #1;
    sb_check("stream_out_4");
    step();
    bus.out_ready = '0;
    #1;
    chk("stream_empty", 160'(bus.out_valid), 160'(5'b00000));

    // Slot 1 stalled, writes to 3 and 4 still proceed
    bus.state = 3'd1; bus.in_data = 32'hAAAA1111; bus.in_valid = 1'b1;
    #1;
    push(1, 32'hAAAA1111);
    step();
    bus.state = 3'd3; bus.in_data = 32'h33333333;
    #1;
    chk("ind_ready3", 160'(bus.in_ready), 160'(1'b1));
    push(3, 32'h33333333);
    step();
    bus.state = 3'd4; bus.in_data = 32'h44444444;
    #1;
    chk("ind_ready4", 160'(bus.in_ready), 160'(1'b1));
    push(4, 32'h44444444);
    step();
    bus.in_valid = 1'b0; bus.state = 3'd1;
    #1;
    chk("ind_blocked1", 160'(bus.in_ready), 160'(1'b0));
    chk("ind_valid", 160'(bus.out_valid), 160'(5'b11010));
    chk("ind_slot1", 160'(bus.out_data[1*DATA_W +: DATA_W]), 160'(32'hAAAA1111));
    bus.out_ready = 5'b11010;
    #1;
    sb_check("ind_s1");
    sb_check("ind_s3");
    sb_check("ind_s4");
    step();
    bus.out_ready = '0;
    #1;
    chk("ind_empty", 160'(bus.out_valid), 160'(5'b00000));

    // Invalid selects
    bus.state = 3'd6; bus.in_valid = 1'b1;
    #1;
    chk("inv6_ready", 160'(bus.in_ready), 160'(1'b1));
    step();
    bus.state = 3'd7;
    #1;
    chk("inv7_ready", 160'(bus.in_ready), 160'(1'b1));
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("inv_valid", 160'(bus.out_valid), 160'(5'b00000));
    chk("inv_err", 160'(bus.err), 160'(1'b1));
    chk("inv_cnt2", 160'(bus.discard_cnt), 160'(8'd2));
    bus.state = 3'd5; bus.in_valid = 1'b1;
    repeat (252) step();
    chk("inv_cnt254", 160'(bus.discard_cnt), 160'(8'd254));
    repeat (48) step();
    bus.in_valid = 1'b0;
    #1;
    chk("inv_sat", 160'(bus.discard_cnt), 160'(8'd255));
    bus.err_clr = 1'b1; bus.state = 3'd7; bus.in_valid = 1'b1;
    step();
    bus.err_clr = 1'b0; bus.in_valid = 1'b0;
    #1;
    chk("clr_set_err", 160'(bus.err), 160'(1'b1));
    chk("clr_set_cnt", 160'(bus.discard_cnt), 160'(8'd1));
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    #1;
    chk("clr_err", 160'(bus.err), 160'(1'b0));
    chk("clr_cnt", 160'(bus.discard_cnt), 160'(8'd0));

    // Asynchronous reset mid-cycle
    bus.state = 3'd0; bus.in_data = 32'h0000000A; bus.in_valid = 1'b1;
    step();
    bus.state = 3'd4; bus.in_data = 32'h0000004B;
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 160'(bus.out_valid), 160'(5'b10001));
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", 160'(bus.out_valid), 160'(5'b00000));
    chk("async_rst_data", bus.out_data, 160'd0);
    #2 reset = 1'b0;
    step();
    bus.state = 3'd4; bus.in_data = 32'h55555555; bus.in_valid = 1'b1;
    #1;
    chk("post_rst_ready", 160'(bus.in_ready), 160'(1'b1));
    chk("post_rst_empty", 160'(bus.out_valid), 160'(5'b00000));
    push(4, 32'h55555555);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("post_rst_valid", 160'(bus.out_valid), 160'(5'b10000));
    sb_check("post_rst_word");
    chk("sb_drained", 160'(sb.size()), 160'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
